eth_rx_depacketizer: RTL and testbench

//  Ingress stage directly downstream of the 64-bit Ethernet MAC RX AXI-Stream.

---
 rtl/eth_rx_depacketizer_pkg.sv | 40 ++++
 rtl/eth_rx_depacketizer_if.sv | 34 +++
 rtl/eth_rx_depacketizer_axis_reg_slice.sv | 61 ++++++
 rtl/eth_rx_depacketizer.sv | 172 +++++++++++++++++
 tb/tb_eth_rx_depacketizer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_rx_depacketizer_pkg.sv
// ---------------------------------------------------------------------------
// eth_rx_depacketizer_pkg
// Shared types and constants for the Galapagos Ethernet ingress depacketizer:
// bus widths, the broadcast MAC, the header length in flits, the receive FSM
// state type, and helpers that pull the big-endian header fields out of a
// little-byte-first 64-bit flit.
// ---------------------------------------------------------------------------
package eth_rx_depacketizer_pkg;

    localparam int DATA_W        = 64;
    localparam int KEEP_W        = DATA_W / 8;
    localparam int RANK_W        = 8;
    localparam int ETH_HDR_FLITS = 2;

    localparam logic [47:0] MAC_BCAST = 48'hffffffffffff;

    typedef enum logic [1:0] {
        HDR0,
        HDR1,
        PAYLOAD,
        DROP
    } rx_state_t;

    // Frame byte k sits at flit bits [8k+7:8k], but the MAC is transmitted
    // most significant byte first, so byte 0 becomes MAC[47:40].
    function automatic logic [47:0] mac_bytes(input logic [DATA_W-1:0] flit);
        logic [47:0] mac;
        mac = '0;
        for (int k = 0; k < 6; k++) begin
            mac[47-8*k -: 8] = flit[8*k +: 8];
        end
        return mac;
    endfunction

    // EtherType occupies bytes 4-5 of the second header flit, byte 4 first.
    function automatic logic [15:0] ethertype_bytes(input logic [DATA_W-1:0] flit);
        return {flit[39:32], flit[47:40]};
    endfunction

endpackage

// File: rtl/eth_rx_depacketizer_if.sv
// ---------------------------------------------------------------------------
// eth_rx_depacketizer_if
// AXI-Stream bundle used on both sides of the depacketizer.
//   tdata  64  frame bytes, byte k at [8k+7:8k]
//   tkeep   8  contiguous byte enables from bit 0
//   tlast   1  end of frame
//   tdest   8  destination rank (meaningful on the router side only)
//   tid     8  source rank (meaningful on the router side only)
//   tvalid  1  source has a flit
//   tready  1  sink accepts the flit
// master drives the payload and tvalid; slave drives tready.
// ---------------------------------------------------------------------------
interface eth_rx_depacketizer_if;
    import eth_rx_depacketizer_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic [RANK_W-1:0] tdest;
    logic [RANK_W-1:0] tid;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata, tkeep, tlast, tdest, tid, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tdest, tid, tvalid,
        output tready
    );

endinterface

// File: rtl/eth_rx_depacketizer_axis_reg_slice.sv
// ---------------------------------------------------------------------------
// axis_reg_slice
// One-deep AXI-Stream output register. Holds data/keep/last/dest/id and
// keeps them stable while out_valid is high and out_ready is low. A new beat
// may be loaded in the same cycle the held one leaves, so a continuous
// out_ready gives one beat per clock.
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake
//   in_data..in_id        beat to register
//   out_valid / out_ready downstream handshake
//   out_data..out_id      registered beat
// ---------------------------------------------------------------------------
module axis_reg_slice
    import eth_rx_depacketizer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    input  logic [RANK_W-1:0] in_dest,
    input  logic [RANK_W-1:0] in_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    output logic [RANK_W-1:0] out_dest,
    output logic [RANK_W-1:0] out_id
);

    // The register can take a beat when empty or when its current beat is
    // leaving this cycle.
    assign in_ready = !out_valid || out_ready;

    // Payload fields only load on an incoming beat so they stay frozen
    // during a stall; valid follows the incoming handshake whenever the
    // register is free to change.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_dest  <= '0;
            out_id    <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
                out_keep <= in_keep;
                out_last <= in_last;
                out_dest <= in_dest;
                out_id   <= in_id;
            end
        end
    end

endmodule

// File: rtl/eth_rx_depacketizer.sv
// ---------------------------------------------------------------------------
// eth_rx_depacketizer
// Ingress stage behind the 64-bit MAC RX stream. Parses the two-flit
// Galapagos header, accepts frames addressed to this FPGA (or broadcast when
// enabled) with the expected EtherType, strips the header and forwards the
// payload tagged with dest/src rank. Rejected frames are swallowed up to
// their last flit and counted.
//   clk, rst     clock, synchronous active-high reset
//   s_axis       slave stream from the MAC (tdest/tid unused)
//   m_axis       master stream to the router, one register stage
//   frames_ok    frames forwarded (saturating)
//   frames_drop  frames rejected on MAC or EtherType (saturating)
//   frames_runt  frames whose tlast arrived inside the header (saturating)
// ---------------------------------------------------------------------------
module eth_rx_depacketizer
    import eth_rx_depacketizer_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR_FPGA = 48'hfa163e55ca02,
    parameter logic [15:0] ETHERTYPE     = 16'h7400,
    parameter bit          ACCEPT_BCAST  = 1'b1,
    parameter int          CNT_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    eth_rx_depacketizer_if.slave  s_axis,
    eth_rx_depacketizer_if.master m_axis,
    output logic [CNT_W-1:0]      frames_ok,
    output logic [CNT_W-1:0]      frames_drop,
    output logic [CNT_W-1:0]      frames_runt
);

    rx_state_t         state;
    rx_state_t         state_next;
    logic              s_ready;
    logic              in_fire;
    logic              slice_ready;
    logic              fwd_valid;
    logic              dst_match;
    logic              type_match;
    logic              latch_rank;
    logic              inc_ok;
    logic              inc_drop;
    logic              inc_runt;
    logic [47:0]       dst_mac;
    logic [RANK_W-1:0] hdr_dest;
    logic [RANK_W-1:0] hdr_src;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Header and discard flits never depend on the output register, so only
    // PAYLOAD can back-pressure the MAC.
    assign s_ready       = !rst && (state != PAYLOAD || slice_ready);
    assign s_axis.tready = s_ready;
    assign in_fire       = s_axis.tvalid && s_ready;
    assign fwd_valid     = in_fire && (state == PAYLOAD);

    // The address and type compares are only consulted in HDR0 / HDR1.
    assign dst_mac    = mac_bytes(s_axis.tdata);
    assign dst_match  = (dst_mac == MAC_ADDR_FPGA) ||
                        (ACCEPT_BCAST && (dst_mac == MAC_BCAST));
    assign type_match = (ethertype_bytes(s_axis.tdata) == ETHERTYPE);

    // State register; a reset mid-frame makes the next accepted flit a header.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR0;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and event decode. Everything moves only on an accepted
    // flit. A tlast on a header flit is a runt even when that same flit would
    // also have failed the filter; only frames that reach DROP count as drops.
    always_comb begin
        state_next = state;
        latch_rank = 1'b0;
        inc_ok     = 1'b0;
        inc_drop   = 1'b0;
        inc_runt   = 1'b0;
        if (in_fire) begin
            unique case (state)
                HDR0: begin
                    if (s_axis.tlast) begin
                        inc_runt   = 1'b1;
                        state_next = HDR0;
                    end else if (dst_match) begin
                        state_next = HDR1;
                    end else begin
                        state_next = DROP;
                    end
                end
                HDR1: begin
                    if (s_axis.tlast) begin
                        inc_runt   = 1'b1;
                        state_next = HDR0;
                    end else if (!type_match) begin
                        state_next = DROP;
                    end else begin
                        latch_rank = 1'b1;
                        state_next = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (s_axis.tlast) begin
                        inc_ok     = 1'b1;
                        state_next = HDR0;
                    end
                end
                DROP: begin
                    if (s_axis.tlast) begin
                        inc_drop   = 1'b1;
                        state_next = HDR0;
                    end
                end
                default: state_next = HDR0;
            endcase
        end
    end

    // Ranks from header bytes 14 and 15, held for the whole payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_dest <= '0;
            hdr_src  <= '0;
        end else if (latch_rank) begin
            hdr_dest <= s_axis.tdata[55:48];
            hdr_src  <= s_axis.tdata[63:56];
        end
    end

    // Statistics counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_ok   <= '0;
            frames_drop <= '0;
            frames_runt <= '0;
        end else begin
            if (inc_ok) begin
                frames_ok <= sat_inc(frames_ok);
            end
            if (inc_drop) begin
                frames_drop <= sat_inc(frames_drop);
            end
            if (inc_runt) begin
                frames_runt <= sat_inc(frames_runt);
            end
        end
    end

    axis_reg_slice u_out_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (fwd_valid),
        .in_ready  (slice_ready),
        .in_data   (s_axis.tdata),
        .in_keep   (s_axis.tkeep),
        .in_last   (s_axis.tlast),
        .in_dest   (hdr_dest),
        .in_id     (hdr_src),
        .out_valid (m_axis.tvalid),
        .out_ready (m_axis.tready),
        .out_data  (m_axis.tdata),
        .out_keep  (m_axis.tkeep),
        .out_last  (m_axis.tlast),
        .out_dest  (m_axis.tdest),
        .out_id    (m_axis.tid)
    );

endmodule

// File: tb/tb_eth_rx_depacketizer.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_depacketizer
// Self-checking bench for eth_rx_depacketizer: reset checks, a hand-built
// good frame, a table of filter/runt cases, a stalled payload, reset in the
// middle of a frame, and randomized frames against a frame-level model.
// ---------------------------------------------------------------------------
module tb_eth_rx_depacketizer;
    import eth_rx_depacketizer_pkg::*;

    localparam logic [47:0] LOCAL_MAC = 48'hfa163e55ca02;
    localparam logic [47:0] OTHER_MAC = 48'hfa163e55ca03;
    localparam logic [47:0] SRC_MAC   = 48'h0cc47a88c047;
    localparam logic [47:0] BCAST_MAC = 48'hffffffffffff;
    localparam logic [15:0] GOOD_TYPE = 16'h7400;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  dest;
        logic [7:0]  id;
    } beat_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } flit_t;

    typedef struct {
        logic [47:0] dst;
        logic [15:0] etype;
        logic [7:0]  dest;
        logic [7:0]  srank;
        int          total;
        logic [7:0]  last_keep;
        bit          chain;
        int          beats;
        int          ok;
        int          drop;
        int          runt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] frames_ok;
    logic [31:0] frames_drop;
    logic [31:0] frames_runt;

    beat_t exp_q[$];
    beat_t got_q[$];
    flit_t tx_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ok   = 0;
    int exp_drop = 0;
    int exp_runt = 0;
    int stall_mode = 0;
    bit mon_en     = 1'b0;
    bit gap_mode   = 1'b0;
    int in_stall_cycles = 0;

    always #5 clk = ~clk;

    eth_rx_depacketizer_if s_bus ();
    eth_rx_depacketizer_if m_bus ();

    eth_rx_depacketizer #(
        .MAC_ADDR_FPGA (LOCAL_MAC),
        .ETHERTYPE     (GOOD_TYPE),
        .ACCEPT_BCAST  (1'b1),
        .CNT_W         (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis      (s_bus),
        .m_axis      (m_bus),
        .frames_ok   (frames_ok),
        .frames_drop (frames_drop),
        .frames_runt (frames_runt)
    );

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Header flit idx (0 or 1) laid out byte by byte, big-endian fields.
    function automatic logic [63:0] hdr_flit(input int idx, input logic [47:0] dst,
                                             input logic [47:0] src, input logic [15:0] etype,
                                             input logic [7:0] dest, input logic [7:0] srank);
        logic [7:0]  hb [16];
        logic [63:0] f;
        for (int k = 0; k < 6; k++) begin
            hb[k]     = dst[47-8*k -: 8];
            hb[6 + k] = src[47-8*k -: 8];
        end
        hb[12] = etype[15:8];
        hb[13] = etype[7:0];
        hb[14] = dest;
        hb[15] = srank;
        f = '0;
        for (int k = 0; k < 8; k++) begin
            f[8*k +: 8] = hb[8*idx + k];
        end
        return f;
    endfunction

    // Output monitor: owns m_axis tready, records beats that will transfer
    // on the coming rising edge, and checks that a stalled beat is held.
    initial begin
        beat_t prev;
        beat_t cur;
        bit    prev_stalled;
        prev_stalled = 1'b0;
        forever begin
            @(negedge clk);
            m_bus.tready = (stall_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            cur.data = m_bus.tdata;
            cur.keep = m_bus.tkeep;
            cur.last = m_bus.tlast;
            cur.dest = m_bus.tdest;
            cur.id   = m_bus.tid;
            if (!mon_en) begin
                prev_stalled = 1'b0;
            end else begin
                if (prev_stalled) begin
                    checkOutput("hold_valid", 64'(m_bus.tvalid), 64'd1);
                    checkOutput("hold_data", cur.data, prev.data);
                end
                if (m_bus.tvalid && m_bus.tready) begin
                    got_q.push_back(cur);
                    prev_stalled = 1'b0;
                end else if (m_bus.tvalid) begin
                    prev_stalled = 1'b1;
                    prev = cur;
                end else begin
                    prev_stalled = 1'b0;
                end
            end
        end
    end

    // Present one flit and hold it until the DUT shows ready; the transfer
    // happens on the following rising edge.
    task automatic applyStimulus(input flit_t f);
        int waited;
        waited = 0;
        @(negedge clk);
        s_bus.tdata  = f.data;
        s_bus.tkeep  = f.keep;
        s_bus.tlast  = f.last;
        s_bus.tvalid = 1'b1;
        #2;
        while (!s_bus.tready) begin
            waited++;
            in_stall_cycles++;
            if (waited > 500) begin
                checkOutput("s_ready_timeout", 64'd0, 64'd1);
                break;
            end
            @(negedge clk);
            #2;
        end
    endtask

    task automatic idleInput(input int n);
        repeat (n) begin
            @(negedge clk);
            s_bus.tvalid = 1'b0;
        end
    endtask

    task automatic sendTx();
        while (tx_q.size() > 0) begin
            if (gap_mode && ($urandom_range(0, 3) == 0)) begin
                idleInput(int'($urandom_range(1, 2)));
            end
            applyStimulus(tx_q.pop_front());
        end
        idleInput(1);
    endtask

    // Queue a frame and predict its outcome from the filtering rules:
    // a single flit is a runt; a foreign MAC is a drop (the DROP state eats
    // even a tlast on flit 1); a good MAC ending on flit 1 is a runt; a
    // wrong EtherType is a drop; otherwise every payload flit is forwarded.
    task automatic buildFrame(input logic [47:0] dst, input logic [15:0] etype,
                              input logic [7:0] dest, input logic [7:0] srank,
                              input int total, input logic [7:0] last_keep);
        flit_t flits[$];
        flit_t f;
        beat_t b;
        bit    mac_ok;
        for (int i = 0; i < total; i++) begin
            f.last = (i == total - 1);
            if (i < ETH_HDR_FLITS) begin
                f.data = hdr_flit(i, dst, SRC_MAC, etype, dest, srank);
                f.keep = 8'hff;
            end else begin
                f.data = {$urandom, $urandom};
                f.keep = f.last ? last_keep : 8'hff;
            end
            flits.push_back(f);
            tx_q.push_back(f);
        end
        mac_ok = (dst == LOCAL_MAC) || (dst == BCAST_MAC);
        if (total == 1)               exp_runt++;
        else if (!mac_ok)             exp_drop++;
        else if (total == 2)          exp_runt++;
        else if (etype != GOOD_TYPE)  exp_drop++;
        else begin
            exp_ok++;
            for (int i = ETH_HDR_FLITS; i < total; i++) begin
                b.data = flits[i].data;
                b.keep = flits[i].keep;
                b.last = flits[i].last;
                b.dest = dest;
                b.id   = srank;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic drainOutput();
        int n;
        int quiet;
        n = 0;
        quiet = 0;
        while (quiet < 4) begin
            @(negedge clk);
            #3;
            if (got_q.size() >= exp_q.size() && !m_bus.tvalid) quiet++;
            else quiet = 0;
            n++;
            if (n > 2000) begin
                checkOutput("drain_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic compareBeats(input string tag);
        int n;
        checkOutput({tag, "_beat_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_beat%0d_data", tag, i), got_q[i].data, exp_q[i].data);
            checkOutput($sformatf("%s_beat%0d_keep_last_dest_id", tag, i),
                        64'({got_q[i].keep, got_q[i].last, got_q[i].dest, got_q[i].id}),
                        64'({exp_q[i].keep, exp_q[i].last, exp_q[i].dest, exp_q[i].id}));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_frames_ok"},   64'(frames_ok),   64'(exp_ok));
        checkOutput({tag, "_frames_drop"}, 64'(frames_drop), 64'(exp_drop));
        checkOutput({tag, "_frames_runt"}, 64'(frames_runt), 64'(exp_runt));
    endtask

    initial begin
        vec_t  vecs [8];
        flit_t f;
        beat_t b;

        vecs[0] = '{OTHER_MAC, GOOD_TYPE, 8'h03, 8'h01, 4, 8'hff, 1'b0, 0, 1, 1, 0};
        vecs[1] = '{LOCAL_MAC, 16'h0800, 8'h03, 8'h01, 5, 8'hff, 1'b1, 0, 1, 2, 0};
        vecs[2] = '{LOCAL_MAC, GOOD_TYPE, 8'h06, 8'h02, 3, 8'h7f, 1'b0, 1, 2, 2, 0};
        vecs[3] = '{LOCAL_MAC, GOOD_TYPE, 8'h03, 8'h01, 2, 8'hff, 1'b0, 0, 2, 2, 1};
        vecs[4] = '{LOCAL_MAC, GOOD_TYPE, 8'h03, 8'h01, 1, 8'hff, 1'b0, 0, 2, 2, 2};
        vecs[5] = '{BCAST_MAC, GOOD_TYPE, 8'h0a, 8'h0c, 3, 8'h03, 1'b0, 1, 3, 2, 2};
        vecs[6] = '{OTHER_MAC, GOOD_TYPE, 8'h03, 8'h01, 2, 8'hff, 1'b0, 0, 3, 3, 2};
        vecs[7] = '{LOCAL_MAC, GOOD_TYPE, 8'h55, 8'h66, 3, 8'h01, 1'b0, 1, 4, 3, 2};

        s_bus.tvalid = 1'b0;
        s_bus.tdata  = '0;
        s_bus.tkeep  = '0;
        s_bus.tlast  = 1'b0;
        s_bus.tdest  = '0;
        s_bus.tid    = '0;
        m_bus.tready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        checkOutput("rst_s_ready", 64'(s_bus.tready), 64'd0);
        checkOutput("rst_m_valid", 64'(m_bus.tvalid), 64'd0);
        checkOutput("rst_tdest_tid", 64'({m_bus.tdest, m_bus.tid}), 64'd0);
        checkCounters("rst");
        @(negedge clk);
        rst = 1'b0;
        #2;
        checkOutput("ready_after_reset", 64'(s_bus.tready), 64'd1);
        mon_en = 1'b1;

        // Hand-built good frame with fixed payload
        $display("[TB] good frame");
        for (int i = 0; i < 2; i++) begin
            f.data = hdr_flit(i, LOCAL_MAC, SRC_MAC, GOOD_TYPE, 8'h03, 8'h01);
            f.keep = 8'hff;
            f.last = 1'b0;
            tx_q.push_back(f);
        end
        tx_q.push_back('{64'h0100000100030000, 8'hff, 1'b0});
        tx_q.push_back('{64'h5073930200000000, 8'h0f, 1'b1});
        exp_q.push_back('{64'h0100000100030000, 8'hff, 1'b0, 8'h03, 8'h01});
        exp_q.push_back('{64'h5073930200000000, 8'h0f, 1'b1, 8'h03, 8'h01});
        exp_ok = 1;
        sendTx();
        drainOutput();
        compareBeats("good1");
        checkOutput("good1_frames_ok", 64'(frames_ok), 64'd1);
        checkOutput("good1_drop_runt", 64'({frames_drop, frames_runt}), 64'd0);

        // Filter / runt table; entry 1 chains into entry 2 back-to-back
        $display("[TB] filter table");
        for (int v = 0; v < 8; v++) begin
            buildFrame(vecs[v].dst, vecs[v].etype, vecs[v].dest, vecs[v].srank,
                       vecs[v].total, vecs[v].last_keep);
            if (!vecs[v].chain) begin
                in_stall_cycles = 0;
                sendTx();
                drainOutput();
                checkOutput($sformatf("vec%0d_beats", v), 64'(got_q.size()), 64'(vecs[v].beats));
                checkOutput($sformatf("vec%0d_s_ready_stalls", v), 64'(in_stall_cycles), 64'd0);
                compareBeats($sformatf("vec%0d", v));
                checkOutput($sformatf("vec%0d_ok", v),   64'(frames_ok),   64'(vecs[v].ok));
                checkOutput($sformatf("vec%0d_drop", v), 64'(frames_drop), 64'(vecs[v].drop));
                checkOutput($sformatf("vec%0d_runt", v), 64'(frames_runt), 64'(vecs[v].runt));
            end
        end

        // Six payload flits with a randomly stalling sink
        $display("[TB] stalled payload");
        stall_mode = 1;
        buildFrame(LOCAL_MAC, GOOD_TYPE, 8'h05, 8'h02, 8, 8'h3f);
        sendTx();
        drainOutput();
        compareBeats("stall");
        checkCounters("stall");
        stall_mode = 0;

        // Reset during payload flit 2, then a fresh frame
        $display("[TB] reset mid-frame");
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f.data = (i < 2) ? hdr_flit(i, LOCAL_MAC, SRC_MAC, GOOD_TYPE, 8'h09, 8'h08)
                             : {$urandom, $urandom};
            f.keep = 8'hff;
            f.last = 1'b0;
            applyStimulus(f);
        end
        @(negedge clk);
        s_bus.tdata  = {$urandom, $urandom};
        s_bus.tlast  = 1'b0;
        s_bus.tvalid = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s_bus.tvalid = 1'b0;
        #2;
        checkOutput("midrst_m_valid", 64'(m_bus.tvalid), 64'd0);
        checkOutput("midrst_tdest", 64'(m_bus.tdest), 64'd0);
        exp_ok = 0;
        exp_drop = 0;
        exp_runt = 0;
        checkCounters("midrst");
        got_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
        buildFrame(LOCAL_MAC, GOOD_TYPE, 8'h0b, 8'h04, 4, 8'h07);
        sendTx();
        drainOutput();
        compareBeats("after_rst");
        checkCounters("after_rst");

        // Randomized frames against the frame-level model
        $display("[TB] random frames");
        gap_mode = 1'b1;
        stall_mode = 1;
        for (int n = 0; n < 40; n++) begin
            logic [47:0] dst;
            int          r;
            r = int'($urandom_range(0, 3));
            if (r < 2)       dst = LOCAL_MAC;
            else if (r == 2) dst = BCAST_MAC;
            else             dst = {16'h0200, $urandom};
            buildFrame(dst, ($urandom_range(0, 4) == 0) ? 16'h0800 : GOOD_TYPE,
                       8'($urandom), 8'($urandom), int'($urandom_range(1, 7)),
                       8'hff >> $urandom_range(0, 7));
        end
        sendTx();
        drainOutput();
        compareBeats("random");
        checkCounters("random");
        stall_mode = 0;
        gap_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
